// File: rtl/bottle_line_pkg.sv
// bottle_line_pkg: lane state encoding and default plant timing shared with controller benches
package bottle_line_pkg;
  typedef enum logic [1:0] {EMPTY, APPROACH, STATION, DEPART} state_e;
  localparam int FEED_GAP       = 4;
  localparam int TRAVEL_TO_FILL = 6;
  localparam int STATION_LEN    = 8;
  localparam int TRAVEL_TO_EXIT = 6;
  localparam int FILL_TARGET    = 8;
  localparam int FILL_TOL       = 1;
  localparam int LEVEL_W        = 6;
  localparam int CNT_W          = 8;
  localparam int POS_W          = 4;
endpackage

// File: rtl/bottle_line_if.sv
// bottle_line_if: controller-to-plant command and sensor bundle for one bottle lane
interface bottle_line_if;
  import bottle_line_pkg::*;
  logic               conveyor_on;
  logic               valve_open;
  logic               supply_en;
  logic               inject_jam;
  logic               bottle_sensor;
  logic               exit_sensor;
  logic               jam_sensor;
  logic               fault;
  logic [LEVEL_W-1:0] fill_level;
  logic [CNT_W-1:0]   good_count;
  logic [CNT_W-1:0]   reject_count;
  logic [CNT_W-1:0]   spill_count;
  modport master (
    output conveyor_on, valve_open, supply_en, inject_jam,
    input  bottle_sensor, exit_sensor, jam_sensor, fault, fill_level,
           good_count, reject_count, spill_count
  );
  modport slave (
    input  conveyor_on, valve_open, supply_en, inject_jam,
    output bottle_sensor, exit_sensor, jam_sensor, fault, fill_level,
           good_count, reject_count, spill_count
  );
endinterface

// File: rtl/bottle_line_emulator_sat_counter.sv
// sat_counter: W-bit incrementer that sticks at all-ones, with synchronous clear
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc_i,
  output logic [W-1:0] count_o
);
  logic [W-1:0] count_q, count_d;
  always_comb count_d = (inc_i && count_q != '1) ? count_q + 1'b1 : count_q;
  always_ff @(posedge clk) count_q <= rst ? '0 : count_d;
  assign count_o = count_q;
endmodule

// File: rtl/bottle_line_emulator.sv
// bottle_line_emulator: conveyor/fill-station/exit plant model that grades bottles and counts spills
module bottle_line_emulator
  import bottle_line_pkg::*;
#(
  parameter int FEED_GAP_P       = FEED_GAP,
  parameter int TRAVEL_TO_FILL_P = TRAVEL_TO_FILL,
  parameter int STATION_LEN_P    = STATION_LEN,
  parameter int TRAVEL_TO_EXIT_P = TRAVEL_TO_EXIT,
  parameter int FILL_TARGET_P    = FILL_TARGET,
  parameter int FILL_TOL_P       = FILL_TOL
) (
  input  logic           clk,
  input  logic           reset,
  bottle_line_if.slave   bus
);
  state_e             state_q, state_d;
  logic [POS_W-1:0]   pos_q, pos_d, gap_q, gap_d, lim;
  logic [LEVEL_W-1:0] fill_q, fill_d;
  logic               bs_q, bs_d, es_q, es_d, jam_q, fault_q, fault_d;
  logic               jam, adv, in_st, good_inc, rej_inc, in_tol;
  assign jam    = bus.inject_jam && state_q != EMPTY;
  assign adv    = bus.conveyor_on && !jam;
  assign in_st  = state_q == STATION;
  assign in_tol = fill_q >= LEVEL_W'(FILL_TARGET_P - FILL_TOL_P) &&
                  fill_q <= LEVEL_W'(FILL_TARGET_P + FILL_TOL_P);
  assign lim    = state_q == APPROACH ? POS_W'(TRAVEL_TO_FILL_P - 1) :
                  state_q == STATION  ? POS_W'(STATION_LEN_P - 1)    :
                                        POS_W'(TRAVEL_TO_EXIT_P - 1);
  always_comb begin
    state_d  = state_q;
    pos_d    = pos_q;
    gap_d    = gap_q;
    fill_d   = (in_st && bus.valve_open && fill_q != '1) ? fill_q + 1'b1 : fill_q;
    fault_d  = fault_q || (in_st && bus.valve_open && bus.conveyor_on);
    bs_d     = 1'b0;
    es_d     = 1'b0;
    good_inc = 1'b0;
    rej_inc  = 1'b0;
    if (state_q == EMPTY) begin
      if (bus.conveyor_on && gap_q != POS_W'(FEED_GAP_P - 1))
        gap_d = gap_q + 1'b1;
      else if (bus.conveyor_on && bus.supply_en) begin
        state_d = APPROACH;
        pos_d   = '0;
        fill_d  = '0;
      end
    end else if (adv) begin
      pos_d = pos_q + 1'b1;
      if (pos_q == lim) begin
        pos_d    = '0;
        state_d  = state_q == APPROACH ? STATION : state_q == STATION ? DEPART : EMPTY;
        bs_d     = state_q == APPROACH;
        es_d     = state_q == DEPART;
        gap_d    = state_q == DEPART ? '0 : gap_q;
        good_inc = state_q == DEPART && in_tol;
        rej_inc  = state_q == DEPART && !in_tol;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= EMPTY;
      pos_q   <= '0;
      gap_q   <= '0;
      fill_q  <= '0;
      bs_q    <= 1'b0;
      es_q    <= 1'b0;
      jam_q   <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pos_q   <= pos_d;
      gap_q   <= gap_d;
      fill_q  <= fill_d;
      bs_q    <= bs_d;
      es_q    <= es_d;
      jam_q   <= jam;
      fault_q <= fault_d;
    end
  end
  logic [CNT_W-1:0] good_cnt, rej_cnt, spill_cnt;
  sat_counter #(.W(CNT_W)) u_good  (.clk(clk), .rst(reset), .inc_i(good_inc), .count_o(good_cnt));
  sat_counter #(.W(CNT_W)) u_rej   (.clk(clk), .rst(reset), .inc_i(rej_inc), .count_o(rej_cnt));
  sat_counter #(.W(CNT_W)) u_spill (.clk(clk), .rst(reset), .inc_i(bus.valve_open && !in_st), .count_o(spill_cnt));
  assign bus.bottle_sensor = bs_q;
  assign bus.exit_sensor   = es_q;
  assign bus.jam_sensor    = jam_q;
  assign bus.fault         = fault_q;
  assign bus.fill_level    = fill_q;
  assign bus.good_count    = good_cnt;
  assign bus.reject_count  = rej_cnt;
  assign bus.spill_count   = spill_cnt;
endmodule

// File: tb/tb_bottle_line_emulator.sv
// tb_bottle_line_emulator: random and directed stimulus against a distance-travelled plant model
module tb_bottle_line_emulator;
  import bottle_line_pkg::*;
  localparam int FMAX = 2**LEVEL_W - 1;
  localparam int CMAX = 2**CNT_W - 1;
  localparam int T1   = TRAVEL_TO_FILL;
  localparam int T12  = TRAVEL_TO_FILL + STATION_LEN;
  localparam int TALL = TRAVEL_TO_FILL + STATION_LEN + TRAVEL_TO_EXIT;
  logic clk = 0, reset = 1;
  always #5 clk = ~clk;
  bottle_line_if bus();
  bottle_line_emulator dut (.clk(clk), .reset(reset), .bus(bus));
  int tests = 0, fails = 0, cyc = 0;
  bit m_present, m_bs, m_es, m_jam, m_fault;
  int m_dist, m_gap, m_fill, m_good, m_rej, m_spill;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", tag, cyc, got, exp);
    end
  endtask
  // Bottle position is tracked as total belt distance since placement.
  task automatic model_step(input bit r, input bit c, input bit v, input bit s, input bit j);
    bit jam, in_st;
    if (r) begin
      m_present = 0; m_bs = 0; m_es = 0; m_jam = 0; m_fault = 0;
      m_dist = 0; m_gap = 0; m_fill = 0; m_good = 0; m_rej = 0; m_spill = 0;
      return;
    end
    jam   = j && m_present;
    in_st = m_present && m_dist >= T1 && m_dist < T12;
    m_bs = 0; m_es = 0; m_jam = jam;
    if (v && in_st) begin
      if (m_fill < FMAX) m_fill++;
      if (c) m_fault = 1;
    end
    if (v && !in_st && m_spill < CMAX) m_spill++;
    if (!m_present) begin
      if (c && m_gap == FEED_GAP - 1 && s) begin m_present = 1; m_dist = 0; m_fill = 0; end
      else if (c && m_gap < FEED_GAP - 1) m_gap++;
    end else if (c && !jam) begin
      m_dist++;
      if (m_dist == T1) m_bs = 1;
      if (m_dist == TALL) begin
        m_es = 1; m_present = 0; m_gap = 0;
        if (m_fill >= FILL_TARGET - FILL_TOL && m_fill <= FILL_TARGET + FILL_TOL) begin
          if (m_good < CMAX) m_good++;
        end else if (m_rej < CMAX) m_rej++;
      end
    end
  endtask
  task automatic tick(input bit r, input bit c, input bit v, input bit s, input bit j);
    @(negedge clk);
    reset = r; bus.conveyor_on = c; bus.valve_open = v; bus.supply_en = s; bus.inject_jam = j;
    @(posedge clk);
    model_step(r, c, v, s, j);
    #1;
    cyc = r ? 0 : cyc + 1;
    check("bottle_sensor", bus.bottle_sensor, m_bs);
    check("exit_sensor", bus.exit_sensor, m_es);
    check("jam_sensor", bus.jam_sensor, m_jam);
    check("fault", bus.fault, m_fault);
    check("fill_level", bus.fill_level, m_fill);
    check("good_count", bus.good_count, m_good);
    check("reject_count", bus.reject_count, m_rej);
    check("spill_count", bus.spill_count, m_spill);
  endtask
  task automatic fill_bottle(input int n, input bit conv_during);
    int k;
    tick(1, 0, 0, 0, 0);
    k = 0;
    while (!bus.bottle_sensor && k < 40) begin tick(0, 1, 0, 1, 0); k++; end
    check("reach_station", bus.bottle_sensor, 1);
    repeat (n) tick(0, conv_during, 1, 0, 0);
    k = 0;
    while (!bus.exit_sensor && k < 40) begin tick(0, 1, 0, 0, 0); k++; end
    check("reach_exit", bus.exit_sensor, 1);
  endtask
  initial begin
    int bs_at, es_at, jam_n, pulses;
    bus.conveyor_on = 0; bus.valve_open = 0; bus.supply_en = 0; bus.inject_jam = 0;
    repeat (2) tick(1, 0, 0, 0, 0);
    bs_at = -1; es_at = -1;
    repeat (30) begin
      tick(0, 1, 0, 1, 0);
      if (bus.bottle_sensor && bs_at < 0) bs_at = cyc;
      if (bus.exit_sensor && es_at < 0) es_at = cyc;
    end
    check("nominal_bs_cycle", bs_at, 10);
    check("nominal_es_cycle", es_at, 24);
    check("nominal_reject", bus.reject_count, 1);
    check("nominal_good", bus.good_count, 0);
    tick(1, 0, 0, 0, 0);
    bs_at = -1; jam_n = 0;
    repeat (30) begin
      tick(0, 1, 0, 1, cyc >= 5 && cyc < 10);
      if (bus.bottle_sensor && bs_at < 0) bs_at = cyc;
      if (bus.jam_sensor) jam_n++;
    end
    check("jam_bs_cycle", bs_at, 15);
    check("jam_sensor_len", jam_n, 5);
    fill_bottle(8, 0);
    check("fill8_level", bus.fill_level, 8);
    check("fill8_good", bus.good_count, 1);
    check("fill8_fault", bus.fault, 0);
    fill_bottle(12, 0);
    check("fill12_level", bus.fill_level, 12);
    check("fill12_reject", bus.reject_count, 1);
    fill_bottle(70, 0);
    check("fill_saturate", bus.fill_level, FMAX);
    fill_bottle(2, 1);
    repeat (10) tick(0, 1, 0, 1, 0);
    check("fault_sticky", bus.fault, 1);
    tick(1, 0, 0, 0, 0);
    repeat (26) tick(0, 1, cyc < 3 || cyc == 20 || cyc == 21, 1, 0);
    check("spill_five", bus.spill_count, 5);
    check("spill_fill", bus.fill_level, 0);
    tick(1, 0, 0, 0, 0);
    repeat (20) tick(0, 1, 0, 1, 0);
    tick(1, 1, 1, 1, 0);
    check("rst_fill", bus.fill_level, 0);
    check("rst_exit", bus.exit_sensor, 0);
    pulses = 0;
    repeat (20) begin
      tick(0, 1, 0, 0, 0);
      pulses += int'(bus.bottle_sensor) + int'(bus.exit_sensor);
    end
    check("no_supply_pulses", pulses, 0);
    tick(1, 0, 0, 0, 0);
    repeat (300) tick(0, 0, 1, 1, 0);
    check("spill_saturate", bus.spill_count, CMAX);
    tick(1, 0, 0, 0, 0);
    repeat (3000)
      tick($urandom_range(0, 999) < 3, $urandom_range(0, 9) < 8, $urandom_range(0, 9) < 3,
           $urandom_range(0, 9) < 9, $urandom_range(0, 19) == 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/bottle_line_emulator.md
Name: bottle_line_emulator

Overview:
- Synthesizable plant model of the conveyor, fill station and exit for one bottle lane. It is the responder side of the filler controller interface.
- Consumes the controller's conveyor_on and valve_open commands. Produces bottle_sensor, exit_sensor and jam_sensor with physically consistent timing.
- Used for closed-loop simulation and FPGA hardware-in-the-loop of bottle_filler.
- Grades every bottle on fill level and counts spills.

Parameters:
- FEED_GAP, 4: conveyor-on cycles spent in EMPTY before the next bottle is placed.
- TRAVEL_TO_FILL, 6: conveyor-on cycles from placement to the fill-station window.
- STATION_LEN, 8: conveyor-on cycles the bottle spends inside the fill window.
- TRAVEL_TO_EXIT, 6: conveyor-on cycles from leaving the window to reaching the exit sensor.
- FILL_TARGET, 8: fill units for a nominal bottle.
- FILL_TOL, 1: allowed +/- deviation from FILL_TARGET.
- LEVEL_W, 6: width of fill_level.
- CNT_W, 8: width of all counters.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- conveyor_on  in  1  controller command: belt moving
- valve_open  in  1  controller command: fill valve open
- supply_en  in  1  allow new bottles to be placed
- inject_jam  in  1  test hook: mechanically block the bottle in flight
- bottle_sensor  out  1  one-cycle pulse: bottle entered the fill window
- exit_sensor  out  1  one-cycle pulse: bottle reached the exit
- jam_sensor  out  1  bottle blocked
- fill_level  out  LEVEL_W  fill units in the current bottle
- good_count  out  CNT_W  bottles exited within tolerance
- reject_count  out  CNT_W  bottles exited under- or overfilled
- spill_count  out  CNT_W  cycles in which valve_open was high with no bottle under the nozzle
- fault  out  1  sticky flag: valve_open and conveyor_on high together while in STATION

Behaviour:
- Reset: synchronous, active-high. Clears the state machine to EMPTY, clears all counters, and drives every output to 0.
- Outputs are registered. bottle_sensor and exit_sensor are high in the same cycle the state register changes.
- "Advance": conveyor_on=1 and jam not active. A jam is active when inject_jam=1 and state != EMPTY.
- States: EMPTY, APPROACH, STATION, DEPART. A single position counter pos is used.
- EMPTY:
  - gap increments on each cycle with conveyor_on=1.
  - When gap==FEED_GAP-1, conveyor_on=1 and supply_en=1: go to APPROACH with pos=0 and fill_level=0.
  - When supply_en=0, gap holds at FEED_GAP-1.
- APPROACH:
  - pos increments on Advance.
  - When pos==TRAVEL_TO_FILL-1 and Advance: go to STATION, pos=0, bottle_sensor=1 for that cycle.
- STATION:
  - fill_level increments on each cycle with valve_open=1, saturating at 2^LEVEL_W-1.
  - valve_open=1 with conveyor_on=1 also sets fault.
  - pos increments on Advance. At STATION_LEN-1 with Advance: go to DEPART, pos=0.
- DEPART:
  - pos increments on Advance.
  - At TRAVEL_TO_EXIT-1 with Advance: exit_sensor=1 and go to EMPTY with gap=0.
  - In the same cycle, increment good_count if |fill_level - FILL_TARGET| <= FILL_TOL, otherwise increment reject_count.
- fill_level holds its value after exit until the next placement.
- Spill: valve_open=1 in EMPTY, APPROACH or DEPART increments spill_count.
- Counters (good_count, reject_count, spill_count): all saturate at 2^CNT_W-1 and never wrap.
- jam_sensor:
  - Registered: equals (inject_jam && state != EMPTY) one cycle late.
  - While a jam is active, pos freezes and no transitions occur.
  - Filling continues during a jam if the bottle is in STATION.
- Simultaneous events in the exit cycle: valve_open=1 during DEPART in the exit cycle counts as a spill, and the exit still proceeds.
- With conveyor_on held at 1 from reset release (cycle 0):
  - bottle_sensor is high in cycle FEED_GAP+TRAVEL_TO_FILL = 10.
  - exit_sensor is high in cycle 10+STATION_LEN+TRAVEL_TO_EXIT = 24.
- Reset mid-flight: the bottle is discarded without grading, and no exit_sensor pulse is produced.

Decomposition:
- Package bottle_line_pkg holds:
  - the state enum (EMPTY, APPROACH, STATION, DEPART) with 2-bit encoding;
  - the default timing constants, shared with bottle_filler benches.
- One sub-module, sat_counter: a CNT_W-wide saturating incrementer with synchronous clear. It is instantiated for good_count, reject_count and spill_count.

Test Plan:
- Conveyor held at 1, supply_en=1, valve never opened -> bottle_sensor in cycle 10, exit_sensor in cycle 24, reject_count=1, good_count=0.
- Conveyor stopped in STATION, valve_open held for 8 cycles, then conveyor resumed -> fill_level=8, good_count=1 at exit, fault=0.
- Valve open for 12 cycles in STATION -> fill_level=12, reject_count increments. Separately, valve open with conveyor on -> fault=1 and remains 1 until reset.
- inject_jam=1 for 5 cycles during APPROACH -> jam_sensor high 5 cycles (one cycle late); bottle_sensor delayed by exactly 5 cycles versus the nominal cycle 10.
- valve_open=1 for 3 cycles in EMPTY, then 2 cycles in DEPART -> spill_count=5, fill_level unchanged.
- Reset asserted during DEPART -> next cycle: all outputs 0, state EMPTY, no exit_sensor pulse. Then supply_en=0 with conveyor on for 20 cycles -> no bottle_sensor pulse.
